// File: rtl/final_cpa_seq_if.sv
// ============================================================================
// final_cpa_seq_if : SUM/CARRY input and resolved-word output handshake bundle
// Optional ovf member present when FINAL_CPA_OVF_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

interface final_cpa_seq_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_row;
    logic [W-1:0] carry_row;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
`ifdef FINAL_CPA_OVF_EN
    logic [1:0]   ovf;
`endif

    modport slave (
`ifdef FINAL_CPA_OVF_EN
        output ovf,
`endif
        input  in_valid,
        output in_ready,
        input  sum_row,
        input  carry_row,
        output out_valid,
        input  out_ready,
        output result
    );

    modport master (
`ifdef FINAL_CPA_OVF_EN
        input  ovf,
`endif
        output in_valid,
        input  in_ready,
        output sum_row,
        output carry_row,
        input  out_valid,
        output out_ready,
        input  result
    );
endinterface

`default_nettype wire

// File: rtl/final_cpa_seq.sv
// ============================================================================
// final_cpa_seq : multi-cycle chunked carry-propagate adder, RESULT = SUM + (CARRY<<1)
// Define FINAL_CPA_OVF_EN to add the 2-bit ovf output.  Rev 1.0
// ============================================================================
`default_nettype none

module final_cpa_seq #(
    parameter int W     = 64,
    parameter int CHUNK = 16
) (
    input  logic           clk,
    input  logic           rst,
    final_cpa_seq_if.slave bus
);
    localparam int N    = W / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    generate
        if (W % CHUNK != 0) begin : g_chunk_check
            $error("final_cpa_seq: W must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic            c_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    result_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [CHUNK:0]  chunk_sum_d;
`ifdef FINAL_CPA_OVF_EN
    logic            top_q;
    logic [1:0]      ovf_q;
`endif

    always_comb begin
        chunk_sum_d = {1'b0, opa_q[idx_q*CHUNK +: CHUNK]}
                    + {1'b0, opb_q[idx_q*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            c_q         <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FINAL_CPA_OVF_EN
            top_q       <= 1'b0;
            ovf_q       <= 2'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // CARRY bit i carries weight i+1; its top bit falls outside the word
                        opa_q      <= bus.sum_row;
                        opb_q      <= {bus.carry_row[W-2:0], 1'b0};
                        idx_q      <= '0;
                        c_q        <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
`ifdef FINAL_CPA_OVF_EN
                        top_q      <= bus.carry_row[W-1];
`endif
                    end
                end
                S_RUN: begin
                    result_q[idx_q*CHUNK +: CHUNK] <= chunk_sum_d[CHUNK-1:0];
                    c_q <= chunk_sum_d[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
`ifdef FINAL_CPA_OVF_EN
                        ovf_q       <= {1'b0, chunk_sum_d[CHUNK]} + {1'b0, top_q};
`endif
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
`ifdef FINAL_CPA_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_final_cpa_seq.sv
// ============================================================================
// tb_final_cpa_seq : directed and streaming checks for final_cpa_seq (W=64, CHUNK=16)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_final_cpa_seq;
    localparam int W = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    final_cpa_seq_if #(.W(W)) bus ();

    final_cpa_seq #(.W(W), .CHUNK(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait for acceptance, then run until out_valid; leaves DUT in HOLD.
    task automatic run_op(input string tag, input logic [63:0] s, input logic [63:0] c,
                          input logic [63:0] exp_res, input logic [1:0] exp_ovf);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check_val({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        bus.sum_row   = s;
        bus.carry_row = c;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.sum_row   = '1;
        bus.carry_row = '1;
        check_val({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.out_valid && n < 20);
        check_val({tag, "_latency"}, 64'(n), 64'd4);
        check_val({tag, "_result"}, bus.result, exp_res);
`ifdef FINAL_CPA_OVF_EN
        check_val({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
`else
        if (exp_ovf > 2'd2) $display("note: ovf expectation out of range in %s", tag);
`endif
    endtask

    task automatic finish_hs(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        check_val({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    logic [63:0] exp_q[$];
    int          sent;
    int          rcvd;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_row   = '0;
        bus.carry_row = '0;
        #2;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_result", bus.result, 64'd0);
`ifdef FINAL_CPA_OVF_EN
        check_val("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        step();
        rst = 1'b0;
        step();

        run_op("basic", 64'h5, 64'h3, 64'hB, 2'd0);
        finish_hs("basic");
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 2'd1);
        finish_hs("ripple");
        run_op("topdrop", 64'h0, 64'h8000_0000_0000_0000, 64'h0, 2'd1);
        finish_hs("topdrop");
        run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFD, 2'd2);
        finish_hs("allones");

        // Backpressure: hold for 5 cycles while a competing pair is offered
        run_op("bp", 64'h1234, 64'h1, 64'h1236, 2'd0);
        bus.sum_row   = 64'hAAAA;
        bus.carry_row = 64'h5555;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_hold_result", bus.result, 64'h1236);
            check_val("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        finish_hs("bp");

        // Reset two cycles into RUN drops the operation
        bus.sum_row   = 64'hFFFF_0000_FFFF_0000;
        bus.carry_row = 64'h0123_4567_89AB_CDEF;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("midrst_result", bus.result, 64'd0);
        check_val("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();
        run_op("postrst", 64'h10, 64'h8, 64'h20, 2'd0);
        finish_hs("postrst");

        // Streaming with random valid/ready on both sides
        sent = 0;
        rcvd = 0;
        fork
            begin : producer
                int cyc;
                cyc = 0;
                while (sent < 100 && cyc < 20000) begin
                    logic acc;
                    if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
                        bus.sum_row   = {$urandom, $urandom};
                        bus.carry_row = {$urandom, $urandom};
                        bus.in_valid  = 1'b1;
                    end
                    acc = bus.in_valid && bus.in_ready;
                    if (acc) exp_q.push_back(bus.sum_row + (bus.carry_row << 1));
                    step();
                    cyc++;
                    if (acc) begin
                        bus.in_valid = 1'b0;
                        sent++;
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (rcvd < 100 && cyc < 20000) begin
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() > 0) begin
                            check_val("stream_result", bus.result, exp_q.pop_front());
                        end else begin
                            check_val("stream_extra", bus.result, 64'hx);
                        end
                        rcvd++;
                    end
                    step();
                    cyc++;
                end
                bus.out_ready = 1'b0;
            end
        join
        check_val("stream_count", 64'(rcvd), 64'd100);
        check_val("stream_leftover", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
